mult_fu: RTL and testbench

Pipelined integer multiply functional unit sitting directly downstream of the reservation station's mult issue port. Accepts one issued mult packet per cycle with its register-file operand values, computes MUL/MULH/MULHSU/MULHU over `STAGES` pipeline stages, and holds the finished result until the CDB arbiter grants it. It tracks branch masks per stage so that squashed work never reaches the CDB. It drives the `fu_mult_busy` bit the RS uses to gate issue.

---
 rtl/mult_fu_if.sv | 64 ++++++
 rtl/mult_fu.sv | 136 +++++++++++++
 tb/tb_mult_fu.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_fu_if.sv
// Shared types for the mult functional unit and its issue/branch/CDB bus.
// The package carries the RS packet and branch types that the interface and the FU both use.
package mult_fu_pkg;
  localparam int BR_MASK_W  = 4;
  localparam int PHYS_REG_W = 6;

  typedef logic [BR_MASK_W-1:0]  BR_MASK;
  typedef logic [PHYS_REG_W-1:0] PHYS_REG_IDX;

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_SQUASH = 2'd1,
    BR_CLEAR  = 2'd2
  } BR_TASK;

  localparam logic [1:0] FUNC_MUL    = 2'd0;
  localparam logic [1:0] FUNC_MULH   = 2'd1;
  localparam logic [1:0] FUNC_MULHSU = 2'd2;
  localparam logic [1:0] FUNC_MULHU  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [1:0] mult_func;
  } DECODED_VALS;

  typedef struct packed {
    PHYS_REG_IDX reg_idx;
  } TAG_T;

  typedef struct packed {
    DECODED_VALS decoded_vals;
    TAG_T        t;
    BR_MASK      b_mask;
  } RS_PACKET;
endpackage

interface mult_fu_if #(parameter int XLEN = 32);
  import mult_fu_pkg::*;

  // Issue: a packet transfers on a clock edge when issue_in.decoded_vals.valid is
  // high and busy is low; busy never looks at issue_in. Completion: a result
  // transfers on an edge when cdb_req and cdb_gnt are both high.
  RS_PACKET        issue_in;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  BR_MASK          br_id;
  BR_TASK          br_task;
  logic            cdb_gnt;
  logic            busy;
  logic            cdb_req;
  PHYS_REG_IDX     result_tag;
  logic [XLEN-1:0] result_value;
  BR_MASK          result_b_mask;

  modport master (
    output issue_in, rs1_val, rs2_val, br_id, br_task, cdb_gnt,
    input  busy, cdb_req, result_tag, result_value, result_b_mask
  );

  modport slave (
    input  issue_in, rs1_val, rs2_val, br_id, br_task, cdb_gnt,
    output busy, cdb_req, result_tag, result_value, result_b_mask
  );
endinterface

// File: rtl/mult_fu.sv
// Pipelined MUL/MULH/MULHSU/MULHU unit with per-stage branch masks and CDB hold.
// Define MULT_ELASTIC_EN for per-stage elastic advance; default freezes the whole pipe.
module mult_fu
  import mult_fu_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int XLEN   = 32
) (
  input  logic      clock,
  input  logic      reset,
  mult_fu_if.slave  bus
);
  localparam int W2    = 2 * XLEN;
  localparam int CHUNK = W2 / STAGES;
  localparam int LAST  = STAGES - 1;

  typedef struct packed {
    logic          valid;
    PHYS_REG_IDX   tag;
    logic [1:0]    func;
    BR_MASK        b_mask;
    logic [W2-1:0] mcand;
    logic [W2-1:0] mplier;
    logic [W2-1:0] psum;
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];

  BR_TASK              br_task;
  BR_MASK              br_id;
  logic [STAGES-1:0]   sq;
  logic [STAGES-1:0]   moves;
  logic                busy;
  logic                req;
  logic                in_sq;
  stage_t              in_stage;

  assign br_task = bus.br_task;
  assign br_id   = bus.br_id;

  function automatic logic squash_hit(input BR_MASK m, input BR_TASK t, input BR_MASK id);
    return (t == BR_SQUASH) && ((m & id) != '0);
  endfunction

  function automatic BR_MASK clear_mask(input BR_MASK m, input BR_TASK t, input BR_MASK id);
    return (t == BR_CLEAR) ? (m & ~id) : m;
  endfunction

  // One shift-add step over CHUNK multiplier bits.
  function automatic stage_t step(input stage_t s);
    stage_t        r;
    logic [W2-1:0] chunk;
    r        = s;
    chunk    = W2'(s.mplier[CHUNK-1:0]);
    r.psum   = s.psum + s.mcand * chunk;
    r.mcand  = s.mcand << CHUNK;
    r.mplier = s.mplier >> CHUNK;
    return r;
  endfunction

  always_comb begin
    sq    = '0;
    moves = '0;
    busy  = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      sq[i] = stage_q[i].valid & squash_hit(stage_q[i].b_mask, br_task, br_id);
    end
`ifdef MULT_ELASTIC_EN
    // A stage may hand off when everything downstream of it is empty or moving.
    moves[LAST] = bus.cdb_gnt | sq[LAST];
    for (int i = LAST - 1; i >= 0; i--) begin
      moves[i] = ~stage_q[i+1].valid | moves[i+1];
    end
    busy = stage_q[0].valid & ~moves[0];
`else
    busy  = stage_q[LAST].valid & ~bus.cdb_gnt;
    moves = {STAGES{~busy}};
`endif
  end

  always_comb begin
    in_stage        = '0;
    in_stage.valid  = bus.issue_in.decoded_vals.valid;
    in_stage.tag    = bus.issue_in.t.reg_idx;
    in_stage.func   = bus.issue_in.decoded_vals.mult_func;
    in_stage.b_mask = bus.issue_in.b_mask;
    in_stage.mcand  = ((in_stage.func == FUNC_MULH) || (in_stage.func == FUNC_MULHSU))
                      ? {{XLEN{bus.rs1_val[XLEN-1]}}, bus.rs1_val}
                      : {{XLEN{1'b0}}, bus.rs1_val};
    in_stage.mplier = (in_stage.func == FUNC_MULH)
                      ? {{XLEN{bus.rs2_val[XLEN-1]}}, bus.rs2_val}
                      : {{XLEN{1'b0}}, bus.rs2_val};
    in_stage.psum   = '0;
    in_sq           = squash_hit(in_stage.b_mask, br_task, br_id);
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      stage_d[i] = stage_q[i];
    end
    // Stage 0 takes the incoming packet (or a bubble) whenever the unit is not busy.
    if (!busy) begin
      stage_d[0]       = step(in_stage);
      stage_d[0].valid = in_stage.valid & ~in_sq;
    end else begin
      stage_d[0].valid = stage_q[0].valid & ~sq[0];
    end
    stage_d[0].b_mask = clear_mask(stage_d[0].b_mask, br_task, br_id);
    for (int i = 1; i < STAGES; i++) begin
      if (moves[i-1]) begin
        stage_d[i]       = step(stage_q[i-1]);
        stage_d[i].valid = stage_q[i-1].valid & ~sq[i-1];
      end else begin
        stage_d[i].valid = stage_q[i].valid & ~sq[i];
      end
      stage_d[i].b_mask = clear_mask(stage_d[i].b_mask, br_task, br_id);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < STAGES; i++) begin
      if (reset) stage_q[i] <= '0;
      else       stage_q[i] <= stage_d[i];
    end
  end

  assign req               = stage_q[LAST].valid & ~sq[LAST];
  assign bus.busy          = busy;
  assign bus.cdb_req       = req;
  assign bus.result_tag    = req ? stage_q[LAST].tag : '0;
  assign bus.result_b_mask = req ? clear_mask(stage_q[LAST].b_mask, br_task, br_id) : '0;
  assign bus.result_value  = !req ? '0
                           : (stage_q[LAST].func == FUNC_MUL) ? stage_q[LAST].psum[XLEN-1:0]
                           : stage_q[LAST].psum[W2-1:XLEN];
endmodule

// File: tb/tb_mult_fu.sv
// Self-checking bench for mult_fu: cycle-scheduled scenarios plus a CDB-side scoreboard.
module tb_mult_fu;
  import mult_fu_pkg::*;

  localparam int XLEN   = 32;
  localparam int STAGES = 4;
  localparam int EW     = PHYS_REG_W + XLEN + BR_MASK_W;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mult_fu_if #(.XLEN(XLEN)) bus ();

  mult_fu #(.STAGES(STAGES), .XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [EW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      2'd1:    p = sa * sb;
      2'd2:    p = sa * $signed(ub);
      default: p = ua * ub;
    endcase
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_issue(input logic [5:0] tag, input logic [1:0] f,
                             input logic [31:0] a, input logic [31:0] b, input logic [3:0] m);
    bus.issue_in.decoded_vals.valid     = 1'b1;
    bus.issue_in.decoded_vals.mult_func = f;
    bus.issue_in.t.reg_idx              = tag;
    bus.issue_in.b_mask                 = m;
    bus.rs1_val                         = a;
    bus.rs2_val                         = b;
  endtask

  task automatic drive_idle();
    bus.issue_in.decoded_vals.valid = 1'b0;
  endtask

  task automatic set_br(input BR_TASK t, input logic [3:0] id);
    bus.br_task = t;
    bus.br_id   = id;
  endtask

  task automatic push_exp(input logic [5:0] tag, input logic [1:0] f,
                          input logic [31:0] a, input logic [31:0] b, input logic [3:0] m);
    exp_q.push_back({tag, model(f, a, b), m});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    logic [EW-1:0] got, want;
    if (!reset) begin
      got = {bus.result_tag, bus.result_value, bus.result_b_mask};
      if (bus.cdb_req) begin
        if (bus.cdb_gnt) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL result_unexpected: got tag=%0d value=%h mask=%b, required no result",
                     bus.result_tag, bus.result_value, bus.result_b_mask);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              n_fail++;
              $display("FAIL result: got {tag,value,mask}=%h required %h", got, want);
            end
          end
        end
      end else begin
        n_cmp++;
        if (got !== '0) begin
          n_fail++;
          $display("FAIL idle_outputs_zero: got %h required 0", got);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    set_br(BR_NONE, 4'd0);
    bus.cdb_gnt = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    n_cmp++; if (bus.busy !== 1'b0)          begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    n_cmp++; if (bus.cdb_req !== 1'b0)       begin n_fail++; $display("FAIL reset_req: got %b required 0", bus.cdb_req); end
    n_cmp++; if (bus.result_tag !== '0)      begin n_fail++; $display("FAIL reset_tag: got %0d required 0", bus.result_tag); end
    n_cmp++; if (bus.result_value !== '0)    begin n_fail++; $display("FAIL reset_value: got %h required 0", bus.result_value); end
    n_cmp++; if (bus.result_b_mask !== '0)   begin n_fail++; $display("FAIL reset_mask: got %b required 0", bus.result_b_mask); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mul_latency();
    bus.cdb_gnt = 1'b1;
    drive_issue(6'd5, FUNC_MUL, 32'd7, 32'd6, 4'd0);
    push_exp(6'd5, FUNC_MUL, 32'd7, 32'd6, 4'd0);
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clock);
      n_cmp++;
      if (bus.cdb_req !== (cyc == 4)) begin
        n_fail++; $display("FAIL latency_req cyc%0d: got %b required %b", cyc, bus.cdb_req, (cyc == 4));
      end
      if (cyc == 4) begin
        n_cmp++; if (bus.result_tag !== 6'd5)     begin n_fail++; $display("FAIL latency_tag: got %0d required 5", bus.result_tag); end
        n_cmp++; if (bus.result_value !== 32'd42) begin n_fail++; $display("FAIL latency_value: got %0d required 42", bus.result_value); end
      end
      tick();
      if (cyc == 0) drive_idle();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  fa [8];
    logic [31:0] aa [8];
    logic [31:0] ba [8];
    fa[0] = FUNC_MULH;   aa[0] = 32'hFFFF_FFFF; ba[0] = 32'hFFFF_FFFF;
    fa[1] = FUNC_MULHU;  aa[1] = 32'hFFFF_FFFF; ba[1] = 32'hFFFF_FFFF;
    fa[2] = FUNC_MULHSU; aa[2] = 32'hFFFF_FFFF; ba[2] = 32'd2;
    fa[3] = FUNC_MUL;    aa[3] = 32'hFFFF_FFFF; ba[3] = 32'hFFFF_FFFF;
    for (int k = 4; k < 8; k++) begin
      fa[k] = 2'($urandom_range(0, 3));
      aa[k] = $urandom;
      ba[k] = $urandom;
    end
    bus.cdb_gnt = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 8) begin
        drive_issue(6'(10 + cyc), fa[cyc], aa[cyc], ba[cyc], 4'd0);
        push_exp(6'(10 + cyc), fa[cyc], aa[cyc], ba[cyc], 4'd0);
      end else begin
        drive_idle();
      end
      @(negedge clock);
      n_cmp++;
      if (bus.cdb_req !== (cyc >= 4 && cyc < 12)) begin
        n_fail++; $display("FAIL b2b_req cyc%0d: got %b required %b", cyc, bus.cdb_req, (cyc >= 4 && cyc < 12));
      end
      if (cyc >= 4 && cyc < 7) begin
        n_cmp++;
        if (bus.result_value !== ((cyc == 4) ? 32'h0 : (cyc == 5) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF)) begin
          n_fail++; $display("FAIL b2b_spec_value cyc%0d: got %h", cyc, bus.result_value);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [1:0]  fa [5];
    logic [31:0] aa [5];
    logic [31:0] ba [5];
    logic [31:0] a_val;
    int          op;
    for (int k = 0; k < 5; k++) begin
      fa[k] = 2'($urandom_range(0, 3));
      aa[k] = $urandom;
      ba[k] = $urandom;
    end
    a_val = model(fa[0], aa[0], ba[0]);
    for (int cyc = 0; cyc < 14; cyc++) begin
      bus.cdb_gnt = !(cyc >= 4 && cyc <= 6);
      op = (cyc < 4) ? cyc : 4;
      if (cyc < 8) drive_issue(6'(20 + op), fa[op], aa[op], ba[op], 4'd0);
      else         drive_idle();
      if (cyc < 4 || cyc == 7) push_exp(6'(20 + op), fa[op], aa[op], ba[op], 4'd0);
      @(negedge clock);
      n_cmp++;
      if (bus.busy !== (cyc >= 4 && cyc <= 6)) begin
        n_fail++; $display("FAIL stall_busy cyc%0d: got %b required %b", cyc, bus.busy, (cyc >= 4 && cyc <= 6));
      end
      n_cmp++;
      if (bus.cdb_req !== (cyc >= 4 && cyc < 12)) begin
        n_fail++; $display("FAIL stall_req cyc%0d: got %b required %b", cyc, bus.cdb_req, (cyc >= 4 && cyc < 12));
      end
      if (cyc >= 4 && cyc <= 6) begin
        n_cmp++;
        if (bus.result_tag !== 6'd20 || bus.result_value !== a_val) begin
          n_fail++; $display("FAIL stall_hold cyc%0d: got tag=%0d value=%h required tag=20 value=%h",
                             cyc, bus.result_tag, bus.result_value, a_val);
        end
      end
      tick();
    end
    bus.cdb_gnt = 1'b1;
  endtask

  task automatic test_squash();
    bus.cdb_gnt = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      case (cyc)
        0: drive_issue(6'd30, FUNC_MUL, 32'd100, 32'd3, 4'b0010);
        1: begin
             drive_issue(6'd31, FUNC_MUL, 32'd9, 32'd11, 4'b0001);
             push_exp(6'd31, FUNC_MUL, 32'd9, 32'd11, 4'b0001);
           end
        default: drive_idle();
      endcase
      if (cyc == 3) set_br(BR_SQUASH, 4'b0010);
      else          set_br(BR_NONE, 4'b0000);
      @(negedge clock);
      n_cmp++;
      if (bus.cdb_req !== (cyc == 5)) begin
        n_fail++; $display("FAIL squash_req cyc%0d: got %b required %b", cyc, bus.cdb_req, (cyc == 5));
      end
      if (cyc == 5) begin
        n_cmp++; if (bus.result_tag !== 6'd31) begin n_fail++; $display("FAIL squash_survivor_tag: got %0d required 31", bus.result_tag); end
      end
      tick();
    end
  endtask

  task automatic test_clear();
    bus.cdb_gnt = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      case (cyc)
        0: begin
             drive_issue(6'd40, FUNC_MULHU, 32'h8000_0001, 32'h0000_0300, 4'b0001);
             push_exp(6'd40, FUNC_MULHU, 32'h8000_0001, 32'h0000_0300, 4'b0000);
           end
        1: begin
             drive_issue(6'd41, FUNC_MULH, 32'hFFFF_FFF0, 32'h0000_0010, 4'b0110);
             push_exp(6'd41, FUNC_MULH, 32'hFFFF_FFF0, 32'h0000_0010, 4'b0100);
           end
        default: drive_idle();
      endcase
      if (cyc == 2)      set_br(BR_CLEAR, 4'b0001);
      else if (cyc == 5) set_br(BR_CLEAR, 4'b0010);
      else               set_br(BR_NONE, 4'b0000);
      @(negedge clock);
      if (cyc == 4) begin
        n_cmp++; if (bus.result_b_mask !== 4'b0000) begin n_fail++; $display("FAIL clear_mask: got %b required 0000", bus.result_b_mask); end
      end
      if (cyc == 5) begin
        n_cmp++; if (bus.result_b_mask !== 4'b0100) begin n_fail++; $display("FAIL clear_same_cycle_mask: got %b required 0100", bus.result_b_mask); end
      end
      tick();
    end
    set_br(BR_NONE, 4'b0000);
  endtask

  task automatic test_squash_grant();
    bus.cdb_gnt = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      case (cyc)
        0: drive_issue(6'd50, FUNC_MUL, 32'd12, 32'd12, 4'b0100);
        1: begin
             drive_issue(6'd51, FUNC_MUL, 32'd13, 32'd13, 4'b0000);
             push_exp(6'd51, FUNC_MUL, 32'd13, 32'd13, 4'b0000);
           end
        default: drive_idle();
      endcase
      if (cyc == 4) set_br(BR_SQUASH, 4'b0100);
      else          set_br(BR_NONE, 4'b0000);
      @(negedge clock);
      n_cmp++;
      if (bus.cdb_req !== (cyc == 5)) begin
        n_fail++; $display("FAIL squash_grant_req cyc%0d: got %b required %b", cyc, bus.cdb_req, (cyc == 5));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bus.cdb_gnt = 1'b1;
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (cyc < 3) drive_issue(6'(60 + cyc), FUNC_MUL, $urandom, $urandom, 4'd0);
      else         drive_idle();
      reset = (cyc == 2);
      @(negedge clock);
      if (cyc >= 3) begin
        n_cmp++;
        if (bus.cdb_req !== 1'b0 || bus.busy !== 1'b0 || bus.result_tag !== '0 ||
            bus.result_value !== '0 || bus.result_b_mask !== '0) begin
          n_fail++;
          $display("FAIL reset_mid cyc%0d: got req=%b busy=%b tag=%0d value=%h mask=%b required all 0",
                   cyc, bus.cdb_req, bus.busy, bus.result_tag, bus.result_value, bus.result_b_mask);
        end
      end
      tick();
    end
  endtask

  initial begin
    bus.issue_in = '0;
    bus.rs1_val  = '0;
    bus.rs2_val  = '0;
    bus.br_id    = '0;
    bus.br_task  = BR_NONE;
    bus.cdb_gnt  = 1'b0;

    test_reset();
    test_mul_latency();
    test_back_to_back();
    test_stall();
    test_squash();
    test_clear();
    test_squash_grant();
    test_reset_mid();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL results_outstanding: got %0d still expected, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
